// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
// Shared definitions for the RAM command path: the 2-bit opcodes carried in
// ram_din[9:8], the command-arbiter FSM state encoding and a small helper
// that packs an opcode and an 8-bit payload into a RAM command word.
package ram_ctrl_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_CMD  = 3'd4,
        RD_WAIT = 3'd5
    } arb_state_t;

    // Build a RAM command word: opcode in the top two bits, payload below.
    function automatic logic [CMD_W-1:0] make_cmd(input logic [1:0] op,
                                                  input logic [DATA_W-1:0] payload);
        return {op, payload};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin selector, purely combinational.
//   req   [1:0] : request bits
//   last        : index of the requester granted most recently
//   grant [1:0] : one-hot grant (all zero when nothing is requested)
//   valid       : some requester is granted
// A lone request always wins; on a tie the requester that was not granted
// last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       valid
);

    // Tie-break toward the requester that did not win last time.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (last) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    assign valid = |req;

endmodule

// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter
// Arbitrates two requesters onto a single serial RAM command port. A write
// is sent as an address command followed by a data command; a read as an
// address command followed by a read command, after which the block waits
// for ram_tx_valid or gives up after TIMEOUT_CYCLES cycles and flags err.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req, we             : per-requester request / direction (1 = write)
//   addr, wdata         : requester n fields at [8n+7:8n]
//   ack                 : one-cycle completion pulse to the granted requester
//   rdata, err          : read data / read-timeout flag, valid with ack
//   ram_din, ram_rx_valid : RAM command word and strobe
//   ram_dout, ram_tx_valid: RAM read data and its valid level
// ack/rdata/err are decoded from registered state so that ack drops on the
// same edge at which the requester releases req; the RAM command outputs
// are likewise a pure decode of registered state and latched fields.
module ram_cmd_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8,
    parameter int N_REQ          = 2   // only two requesters are supported
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     we,
    input  logic [8*N_REQ-1:0]   addr,
    input  logic [8*N_REQ-1:0]   wdata,
    output logic [N_REQ-1:0]     ack,
    output logic [7:0]           rdata,
    output logic                 err,
    output logic [9:0]           ram_din,
    output logic                 ram_rx_valid,
    input  logic [7:0]           ram_dout,
    input  logic                 ram_tx_valid
);

    localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  TMO_ONE  = CW'(1'b1);

    arb_state_t     state_r;
    arb_state_t     state_n_s;
    logic           prio_r;       // requester holding priority on a tie
    logic           gnt_r;        // index of the requester being served
    logic [7:0]     addr_r;
    logic [7:0]     wdata_r;
    logic [CW-1:0]  tmo_cnt_r;

    logic [1:0]     arb_grant_s;
    logic           arb_valid_s;
    logic           gnt_idx_s;
    logic           load_s;
    logic           tmo_clr_s;
    logic           tmo_inc_s;
    logic [1:0]     ack_s;
    logic [7:0]     rdata_s;
    logic           err_s;
    logic [9:0]     cmd_s;
    logic           cmd_valid_s;
    logic [1:0]     ack_gnt_s;

    // The arbiter wants the last winner; that is simply the non-priority one.
    rr_arb2 u_rr_arb2 (
        .req   (req),
        .last  (~prio_r),
        .grant (arb_grant_s),
        .valid (arb_valid_s)
    );

    assign gnt_idx_s = arb_grant_s[1];
    assign ack_gnt_s = gnt_r ? 2'b10 : 2'b01;

    // State register, transaction latches, priority pointer and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            prio_r    <= 1'b0;
            gnt_r     <= 1'b0;
            addr_r    <= 8'h00;
            wdata_r   <= 8'h00;
            tmo_cnt_r <= '0;
        end else begin
            state_r <= state_n_s;
            if (load_s) begin
                // The pointer only moves when a grant is actually made.
                prio_r  <= ~gnt_idx_s;
                gnt_r   <= gnt_idx_s;
                addr_r  <= addr[{gnt_idx_s, 3'b000} +: 8];
                wdata_r <= wdata[{gnt_idx_s, 3'b000} +: 8];
            end
            if (tmo_clr_s) begin
                tmo_cnt_r <= '0;
            end else if (tmo_inc_s) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
            end
        end
    end

    // Next-state and output decode; everything idles at zero by default.
    always_comb begin
        state_n_s   = state_r;
        load_s      = 1'b0;
        tmo_clr_s   = 1'b0;
        tmo_inc_s   = 1'b0;
        ack_s       = 2'b00;
        rdata_s     = 8'h00;
        err_s       = 1'b0;
        cmd_s       = 10'h000;
        cmd_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (arb_valid_s) begin
                    load_s = 1'b1;
                    if (we[gnt_idx_s]) begin
                        state_n_s = WR_ADDR;
                    end else begin
                        state_n_s = RD_ADDR;
                    end
                end else begin
                    state_n_s = IDLE;
                end
            end
            WR_ADDR: begin
                cmd_valid_s = 1'b1;
                cmd_s       = make_cmd(OP_WR_ADDR, addr_r);
                state_n_s   = WR_DATA;
            end
            WR_DATA: begin
                cmd_valid_s = 1'b1;
                cmd_s       = make_cmd(OP_WR_DATA, wdata_r);
                ack_s       = ack_gnt_s;
                state_n_s   = IDLE;
            end
            RD_ADDR: begin
                cmd_valid_s = 1'b1;
                cmd_s       = make_cmd(OP_RD_ADDR, addr_r);
                state_n_s   = RD_CMD;
            end
            RD_CMD: begin
                cmd_valid_s = 1'b1;
                cmd_s       = make_cmd(OP_RD_DATA, 8'h00);
                tmo_clr_s   = 1'b1;
                state_n_s   = RD_WAIT;
            end
            RD_WAIT: begin
                if (ram_tx_valid) begin
                    ack_s     = ack_gnt_s;
                    rdata_s   = ram_dout;
                    state_n_s = IDLE;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    // Give up: complete the read with an error and zero data.
                    ack_s     = ack_gnt_s;
                    err_s     = 1'b1;
                    state_n_s = IDLE;
                end else begin
                    tmo_inc_s = 1'b1;
                    state_n_s = RD_WAIT;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    assign ack          = ack_s;
    assign rdata        = rdata_s;
    assign err          = err_s;
    assign ram_din      = cmd_s;
    assign ram_rx_valid = cmd_valid_s;

endmodule

// File: doc/ram_cmd_arbiter.md
RAM_CMD_ARBITER -- requirements
Module: ram_cmd_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8, SHALL set the maximum cycles in RD_WAIT before a read is aborted.
REQ-002 Parameter N_REQ, default 2, SHALL set the requester count; only 2 is supported.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  2  per-requester request; held high with fields stable until the matching ack bit.
REQ-006 we  input  2  per-requester direction: 1 = write, 0 = read.
REQ-007 addr  input  16  requester n address at [8n+7:8n].
REQ-008 wdata  input  16  requester n write data at [8n+7:8n].
REQ-009 ack  output  2  one-cycle completion pulse to the granted requester.
REQ-010 rdata  output  8  read data, valid only while an ack bit is high for a read.
REQ-011 err  output  1  one-cycle pulse, coincident with ack, when a read timed out.
REQ-012 ram_din  output  10  RAM command word: [9:8] opcode, [7:0] payload.
REQ-013 ram_rx_valid  output  1  RAM command strobe.
REQ-014 ram_dout  input  8  RAM read data.
REQ-015 ram_tx_valid  input  1  RAM read-data valid (level; cleared by the next RAM command).

Function
REQ-016 FSM states SHALL be: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT.
REQ-017 In IDLE with any req bit high, the FSM SHALL grant one requester, latch its we/addr/wdata, and go to WR_ADDR (we=1) or RD_ADDR (we=0).
REQ-018 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; after reset requester 0 has priority.
REQ-019 WR_ADDR SHALL drive ram_rx_valid=1, ram_din={2'b00, addr}, and go to WR_DATA.
REQ-020 WR_DATA SHALL drive ram_rx_valid=1, ram_din={2'b01, wdata}, assert ack[granted], and go to IDLE.
REQ-021 RD_ADDR SHALL drive ram_rx_valid=1, ram_din={2'b10, addr}, and go to RD_CMD.
REQ-022 RD_CMD SHALL drive ram_rx_valid=1, ram_din={2'b11, 8'h00}, clear the timeout counter, and go to RD_WAIT.
REQ-023 In RD_WAIT with ram_tx_valid=1, the block SHALL drive ram_rx_valid=0, assert ack[granted], drive rdata=ram_dout, and go to IDLE.
REQ-024 In RD_WAIT with ram_tx_valid=0, the timeout counter SHALL increment; on reaching TIMEOUT_CYCLES-1 the block SHALL assert ack, assert err, drive rdata=8'h00, and go to IDLE.
REQ-025 ack, rdata and err SHALL be combinational from the registered state, grant and ram_tx_valid, so ack falls at the same edge the requester drops req.
REQ-026 Write latency SHALL be 3 cycles from the req-sampling edge to ack; nominal read latency SHALL be 4 cycles.
REQ-027 ram_rx_valid SHALL be 0 in IDLE and RD_WAIT; ram_din SHALL be 10'h000 whenever ram_rx_valid=0.
REQ-028 A req edge arriving outside IDLE SHALL be ignored until the FSM returns to IDLE; there SHALL be no preemption.
REQ-029 The round-robin pointer SHALL update only on grant.

Reset
REQ-030 Under reset: state=IDLE, pointer=requester 0, timeout counter=0, latched fields=0, ack=0, err=0, rdata=0, ram_rx_valid=0, ram_din=0.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction with no ack; the requester re-issues the request after reset.

Structure
REQ-032 Shared package ram_ctrl_pkg SHALL hold the opcode constants (OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11) and the FSM state enum.
REQ-033 Round-robin selection SHALL be a sub-module rr_arb2 (inputs req, last; outputs grant, valid).

Verification
REQ-034 Write requester 0, addr=8'h3C, wdata=8'hA5 -> RAM commands 10'h03C then 10'h1A5 on consecutive cycles; ack=2'b01 on the second.
REQ-035 Read requester 1, addr=8'h3C after REQ-034 -> commands 10'h23C, 10'h300; ack=2'b10 with rdata=8'hA5, err=0.
REQ-036 Both requesters request in the same cycle, repeatedly -> grants alternate 0,1,0,1; no requester is starved.
REQ-037 Read with RAM model holding ram_tx_valid=0 -> ack and err pulse together with rdata=8'h00 exactly TIMEOUT_CYCLES cycles after RD_CMD; FSM returns to IDLE.
REQ-038 rst_n pulsed low during WR_DATA -> all outputs 0 immediately, no ack; a re-issued write completes normally.
